// File: rtl/saida_display_pkg.sv
// Shared definitions for the saida_display output stage: FSM state
// encoding, active-low 7-segment codes (bit order g..a) and the helper
// that sizes the shift counter.
package saida_display_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        ATUALIZA = 2'd2
    } estado_t;

    localparam logic [6:0] SEG_0       = 7'b1000000;
    localparam logic [6:0] SEG_1       = 7'b1111001;
    localparam logic [6:0] SEG_2       = 7'b0100100;
    localparam logic [6:0] SEG_3       = 7'b0110000;
    localparam logic [6:0] SEG_4       = 7'b0011001;
    localparam logic [6:0] SEG_5       = 7'b0010010;
    localparam logic [6:0] SEG_6       = 7'b0000010;
    localparam logic [6:0] SEG_7       = 7'b1111000;
    localparam logic [6:0] SEG_8       = 7'b0000000;
    localparam logic [6:0] SEG_9       = 7'b0010000;
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;
    localparam logic [6:0] SEG_MENOS   = 7'b0111111;

    // Bits needed to count 0..largura shifts.
    function automatic int larguraContador(input int largura);
        return $clog2(largura + 1);
    endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// One BCD digit to active-low 7-segment code (g..a), with blank enable.
// Non-decimal codes are shown blank.
module decodificador_7seg
    import saida_display_pkg::*;
(
    input  logic [3:0] digito,
    input  logic       apagar,
    output logic [6:0] segmentos
);

    // Digit lookup; blank overrides everything.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        segmentos = SEG_APAGADO;
        if (!apagar) begin
            case (digito)
                4'd0:    segmentos = SEG_0;
                4'd1:    segmentos = SEG_1;
                4'd2:    segmentos = SEG_2;
                4'd3:    segmentos = SEG_3;
                4'd4:    segmentos = SEG_4;
                4'd5:    segmentos = SEG_5;
                4'd6:    segmentos = SEG_6;
                4'd7:    segmentos = SEG_7;
                4'd8:    segmentos = SEG_8;
                4'd9:    segmentos = SEG_9;
                default: segmentos = SEG_APAGADO;
            endcase
        end
    end

endmodule

// File: rtl/saida_display.sv
// Output stage after the processor OUT register: sequential double-dabble
// binary-to-BCD conversion (one shift per clock) feeding active-low
// 7-segment displays with leading-zero blanking.
// Optional macro SAIDA_SINAL_EN: treat the input as two's complement and
// drive a minus sign on sinal_seg; otherwise sinal_seg stays blank.
module saida_display
    import saida_display_pkg::*;
#(
    parameter int LARGURA = 16,
    parameter int DIGITOS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            valor,
    input  logic                   carrega,
    output logic                   ocupado,
    output logic [4*DIGITOS-1:0]   bcd,
    output logic [7*DIGITOS-1:0]   segmentos,
    output logic [6:0]             sinal_seg
);

    localparam int LC = larguraContador(LARGURA);
    localparam logic [LC-1:0] ULTIMO_DESLOC = LC'(LARGURA - 1);

    estado_t              estado, proximoEstado;
    logic [LARGURA-1:0]   regDeslocamento, valorPendente, fonte, magnitude;
    logic [4*DIGITOS-1:0] rascunho, ajustado;
    logic [LC-1:0]        contador;
    logic                 pendente, iniciaConversao;
    logic [DIGITOS-1:0]   apagar;
    logic                 acimaZero;

    // Upper bits of valor are deliberately ignored.
    if (LARGURA < 32) begin : gIgnorados
        logic unusedAltos;
        assign unusedAltos = ^valor[31:LARGURA];
    end

    // State register.
    // NOTE: sequential state is written with non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= proximoEstado;
    end

    // Next state, busy flag and selection of the value that starts a conversion;
    // a strobe on the update edge beats an older pending value.
    always_comb begin
        proximoEstado   = estado;
        iniciaConversao = 1'b0;
        ocupado         = 1'b1;
        fonte           = valor[LARGURA-1:0];
        case (estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (carrega) begin
                    iniciaConversao = 1'b1;
                    proximoEstado   = CONVERTE;
                end
            end
            CONVERTE: begin
                if (contador == ULTIMO_DESLOC) proximoEstado = ATUALIZA;
            end
            ATUALIZA: begin
                if (carrega) begin
                    iniciaConversao = 1'b1;
                    proximoEstado   = CONVERTE;
                end else if (pendente) begin
                    iniciaConversao = 1'b1;
                    fonte           = valorPendente;
                    proximoEstado   = CONVERTE;
                end else begin
                    proximoEstado = OCIOSO;
                end
            end
            default: proximoEstado = OCIOSO;
        endcase
    end

`ifdef SAIDA_SINAL_EN
    logic negativoNovo, negativoRascunho, negativoExibido;

    assign negativoNovo = fonte[LARGURA-1];
    // Most negative value negates to itself, which read unsigned is 2^(LARGURA-1).
    assign magnitude    = negativoNovo ? (~fonte + LARGURA'(1)) : fonte;
    assign sinal_seg    = negativoExibido ? SEG_MENOS : SEG_APAGADO;

    // Sign follows its value: captured at start, shown at the update edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            negativoRascunho <= 1'b0;
            negativoExibido  <= 1'b0;
        end else begin
            if (iniciaConversao)    negativoRascunho <= negativoNovo;
            if (estado == ATUALIZA) negativoExibido  <= negativoRascunho;
        end
    end
`else
    assign magnitude = fonte;
    assign sinal_seg = SEG_APAGADO;
`endif

    // Add-3 correction on every scratch digit of 5 or more before the shift.
    always_comb begin
        ajustado = rascunho;
        for (int d = 0; d < DIGITOS; d++) begin
            if (rascunho[4*d +: 4] >= 4'd5) ajustado[4*d +: 4] = rascunho[4*d +: 4] + 4'd3;
        end
    end

    // Conversion datapath, latest-strobe-wins pending slot and the visible BCD register.
    always_ff @(posedge clk) begin
        if (rst) begin
            regDeslocamento <= '0;
            rascunho        <= '0;
            contador        <= '0;
            pendente        <= 1'b0;
            valorPendente   <= '0;
            bcd             <= '0;
        end else begin
            if (estado == CONVERTE && carrega) begin
                pendente      <= 1'b1;
                valorPendente <= valor[LARGURA-1:0];
            end else if (estado == ATUALIZA) begin
                pendente <= 1'b0;
            end

            if (estado == CONVERTE) begin
                rascunho        <= (ajustado << 1) | {{(4*DIGITOS-1){1'b0}}, regDeslocamento[LARGURA-1]};
                regDeslocamento <= regDeslocamento << 1;
                contador        <= contador + LC'(1);
            end

            if (estado == ATUALIZA) bcd <= rascunho;

            if (iniciaConversao) begin
                regDeslocamento <= magnitude;
                rascunho        <= '0;
                contador        <= '0;
            end
        end
    end

    // Blank every digit above the most significant nonzero one; digit 0 always shows.
    always_comb begin
        apagar    = '0;
        acimaZero = 1'b1;
        for (int d = DIGITOS - 1; d > 0; d--) begin
            acimaZero = acimaZero && (bcd[4*d +: 4] == 4'd0);
            apagar[d] = acimaZero;
        end
    end

    for (genvar d = 0; d < DIGITOS; d++) begin : gDisplay
        decodificador_7seg uDecodificador (
            .digito    (bcd[4*d +: 4]),
            .apagar    (apagar[d]),
            .segmentos (segmentos[7*d +: 7])
        );
    end

endmodule
